// File: rtl/cpu_pkg.sv
// Shared types and default sizes for the program loader and its address counter.
package cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_RELEASE = 3'd4
    } loader_state_t;

endpackage

// File: rtl/load_addr_counter.sv
// Loader write-address counter: synchronous clear, saturating increment, terminal-count flag.
module load_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    logic [ADDR_W-1:0] count_r;

    // Count register; holds at the last address so a stream can never wrap over address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (inc && !tc) begin
            count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = &count_r;

endmodule

// File: rtl/program_loader.sv
// Halts the CPU at an instruction boundary, streams loader bytes into RAM, then pulses CPU reset.
module program_loader
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              fetch_boundary,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic              load_busy
);

    loader_state_t     state_r;
    loader_state_t     state_s;

    logic              hs_s;
    logic              cnt_clr_s;
    logic [ADDR_W-1:0] cnt_s;
    logic              cnt_tc_s;

    logic              wr_pend_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;

    assign hs_s      = ld_valid && (state_r == ST_LOAD);
    assign cnt_clr_s = (state_r == ST_DRAIN) && fetch_boundary;

    load_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .inc   (hs_s),
        .count (cnt_s),
        .tc    (cnt_tc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a last byte landing on the final address still takes a single step to FLUSH.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (load_start) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fetch_boundary) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                if (hs_s && (ld_last || cnt_tc_s)) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_FLUSH:   state_s = ST_RELEASE;
            ST_RELEASE: state_s = ST_RUN;
            default:    state_s = ST_RUN;
        endcase
    end

    // One-deep write stage: an accepted byte reaches RAM on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
        end else if (hs_s) begin
            wr_pend_r <= 1'b1;
            wr_addr_r <= cnt_s;
            wr_data_r <= ld_data;
        end else begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        ld_ready  = 1'b0;
        cpu_hold  = 1'b0;
        cpu_rst   = 1'b0;
        load_busy = 1'b0;
        case (state_r)
            ST_RUN: begin
                ld_ready  = 1'b0;
                cpu_hold  = 1'b0;
                load_busy = 1'b0;
            end
            ST_DRAIN, ST_FLUSH: begin
                cpu_hold  = 1'b1;
                load_busy = 1'b1;
            end
            ST_LOAD: begin
                ld_ready  = 1'b1;
                cpu_hold  = 1'b1;
                load_busy = 1'b1;
            end
            ST_RELEASE: begin
                cpu_rst   = 1'b1;
                cpu_hold  = 1'b1;
                load_busy = 1'b1;
            end
            default: begin
                ld_ready  = 1'b0;
                cpu_hold  = 1'b0;
                cpu_rst   = 1'b0;
                load_busy = 1'b0;
            end
        endcase
    end

    // RAM port mux: CPU passes straight through only in RUN; otherwise only loader writes get out.
    always_comb begin
        ram_addr  = wr_addr_r;
        ram_wdata = wr_data_r;
        ram_we    = 1'b0;
        if (state_r == ST_RUN) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end else begin
            ram_addr  = wr_addr_r;
            ram_wdata = wr_data_r;
            ram_we    = wr_pend_r;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with a behavioural RAM/handshake model.
module tb_program_loader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              load_start;
    logic              fetch_boundary;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              cpu_hold;
    logic              cpu_rst;
    logic              load_busy;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    logic [DATA_W-1:0] phys_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem  [DEPTH];
    logic [DATA_W-1:0] stim_q   [$];

    program_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .fetch_boundary (fetch_boundary),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .cpu_hold       (cpu_hold),
        .cpu_rst        (cpu_rst),
        .load_busy      (load_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The RAM the loader drives, plus a count of CPU reset pulses.
    always @(negedge clk) begin
        if (ram_we) phys_mem[ram_addr] = ram_wdata;
        if (cpu_rst) pulses = pulses + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (phys_mem[i] !== exp_mem[i]) begin
                bad++;
                $display("FAIL %s addr=%0d got=0x%0h exp=0x%0h", tag, i, phys_mem[i], exp_mem[i]);
            end
        end
        n_checks++;
        if (bad != 0) n_errors++;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        check_val("run_we", ram_we, 1);
        check_val("run_addr", ram_addr, a);
        check_val("run_wdata", ram_wdata, d);
        check_val("run_hold", cpu_hold, 0);
        exp_mem[a] = d;
        next_cycle();
        cpu_we = 1'b0;
    endtask

    // One complete load session driven from stim_q; abort_after >= 0 resets after that many bytes.
    task automatic run_load(input bit use_last, input int bdelay, input int gap_pct,
                            input bit noisy, input int abort_after);
        int idx = 0;
        int addr = 0;
        int guard = 0;
        bit prev_hs = 0;
        bit done = 0;
        logic [ADDR_W-1:0] prev_addr = '0;
        logic [DATA_W-1:0] prev_data = '0;
        pulses = 0;
        load_start = 1'b1; fetch_boundary = 1'b0; cpu_we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        next_cycle();
        for (int k = 0; k <= bdelay; k++) begin
            load_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            fetch_boundary = (k == bdelay);
            ld_valid = 1'($urandom_range(0, 1));
            cpu_we = 1'b1; cpu_addr = ADDR_W'($urandom); cpu_wdata = DATA_W'($urandom);
            @(negedge clk);
            check_val("drain_hold", cpu_hold, 1);
            check_val("drain_ready", ld_ready, 0);
            check_val("drain_we", ram_we, 0);
            check_val("drain_busy", load_busy, 1);
            next_cycle();
        end
        while (!done && guard < 400) begin
            ld_valid = ($urandom_range(0, 99) >= gap_pct);
            ld_data = (idx < stim_q.size()) ? stim_q[idx] : DATA_W'($urandom);
            ld_last = use_last && (idx == stim_q.size() - 1);
            load_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            fetch_boundary = 1'($urandom_range(0, 1));
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = ADDR_W'($urandom); cpu_wdata = DATA_W'($urandom);
            @(negedge clk);
            check_val("load_ready", ld_ready, 1);
            check_val("load_hold", cpu_hold, 1);
            check_val("load_cpu_rst", cpu_rst, 0);
            check_val("load_we", ram_we, prev_hs);
            if (prev_hs) begin
                check_val("load_addr", ram_addr, prev_addr);
                check_val("load_wdata", ram_wdata, prev_data);
            end
            prev_hs = ld_valid;
            if (ld_valid) begin
                exp_mem[addr] = ld_data;
                prev_addr = ADDR_W'(addr);
                prev_data = ld_data;
                done = ld_last || (addr == DEPTH - 1);
                addr++;
                idx++;
            end
            next_cycle();
            guard++;
            if (abort_after >= 0 && idx == abort_after && !done) break;
        end
        check_val("load_timeout", guard < 400, 1);
        if (abort_after >= 0 && !done) begin
            ld_valid = 1'b0; cpu_we = 1'b0; load_start = 1'b0;
            @(negedge clk);
            check_val("abort_prev_we", ram_we, prev_hs);
            next_cycle();
            rst = 1'b1;
            #1;
            check_val("abort_busy", load_busy, 0);
            check_val("abort_hold", cpu_hold, 0);
            check_val("abort_ready", ld_ready, 0);
            check_val("abort_cpu_rst", cpu_rst, 0);
            check_val("abort_we", ram_we, 0);
            next_cycle();
            rst = 1'b0;
            for (int k = 0; k < 4; k++) next_cycle();
            check_val("abort_pulses", pulses, 0);
            check_mem("abort_mem");
            return;
        end
        ld_valid = 1'b1; ld_data = DATA_W'($urandom); ld_last = 1'b0;
        cpu_we = 1'b1; cpu_addr = ADDR_W'($urandom); load_start = 1'b0;
        @(negedge clk);
        check_val("flush_ready", ld_ready, 0);
        check_val("flush_we", ram_we, 1);
        check_val("flush_addr", ram_addr, prev_addr);
        check_val("flush_wdata", ram_wdata, prev_data);
        check_val("flush_cpu_rst", cpu_rst, 0);
        check_val("flush_hold", cpu_hold, 1);
        next_cycle();
        @(negedge clk);
        check_val("rel_cpu_rst", cpu_rst, 1);
        check_val("rel_hold", cpu_hold, 1);
        check_val("rel_we", ram_we, 0);
        check_val("rel_ready", ld_ready, 0);
        next_cycle();
        ld_valid = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check_val("run_busy", load_busy, 0);
        check_val("run_hold", cpu_hold, 0);
        check_val("run_cpu_rst", cpu_rst, 0);
        check_val("run_pulses", pulses, 1);
        next_cycle();
        check_mem("load_mem");
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; fetch_boundary = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] v;
            v = DATA_W'($urandom);
            phys_mem[i] = v;
            exp_mem[i] = v;
        end
        #3;
        check_val("rst_busy", load_busy, 0);
        check_val("rst_hold", cpu_hold, 0);
        check_val("rst_ready", ld_ready, 0);
        check_val("rst_cpu_rst", cpu_rst, 0);
        check_val("rst_we", ram_we, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        cpu_write(4'h7, 8'hA5);

        stim_q = '{8'h51, 8'h2E, 8'hE0, 8'hF0};
        run_load(1'b1, 0, 0, 1'b0, -1);

        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(DATA_W'(i));
        run_load(1'b0, 0, 0, 1'b0, -1);

        stim_q = '{8'h11, 8'h22, 8'h33};
        run_load(1'b1, 5, 0, 1'b0, -1);

        stim_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        run_load(1'b1, 0, 0, 1'b0, 2);

        cpu_write(4'h7, 8'h3C);

        for (int t = 0; t < 6; t++) begin
            int n;
            bit use_last;
            use_last = 1'($urandom_range(0, 1));
            n = use_last ? int'($urandom_range(1, 16)) : 16;
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(DATA_W'($urandom));
            run_load(use_last, int'($urandom_range(0, 3)), int'($urandom_range(0, 60)), 1'b1, -1);
            cpu_write(ADDR_W'($urandom), DATA_W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width; depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to enter load mode.
REQ-006 SHALL have port fetch_boundary  input  1  high when CPU micro-step counter is 0.
REQ-007 SHALL have port ld_valid  input  1  loader byte valid.
REQ-008 SHALL have port ld_data  input  DATA_W  loader byte.
REQ-009 SHALL have port ld_last  input  1  marks final byte, qualified by ld_valid.
REQ-010 SHALL have port ld_ready  output  1  loader byte accepted when ld_valid&&ld_ready.
REQ-011 SHALL have ports cpu_addr/cpu_wdata/cpu_we  input  ADDR_W/DATA_W/1  CPU-side RAM access.
REQ-012 SHALL have ports ram_addr/ram_wdata/ram_we  output  ADDR_W/DATA_W/1  muxed RAM access.
REQ-013 SHALL have port cpu_hold  output  1  drives CPU clock halt while loader owns RAM.
REQ-014 SHALL have port cpu_rst  output  1  one-cycle CPU reset pulse after load.
REQ-015 SHALL have port load_busy  output  1  high in any state other than RUN.

Function
REQ-016 SHALL implement FSM RUN, DRAIN, LOAD, FLUSH, RELEASE.
REQ-017 RUN: ram_* SHALL pass cpu_* combinationally; cpu_hold=0; load_start -> DRAIN.
REQ-018 DRAIN: cpu_hold=1; SHALL wait for fetch_boundary=1, then -> LOAD, addr counter cleared to 0.
REQ-019 LOAD: ld_ready=1; each handshake SHALL register ld_data and address, producing ram_we=1 exactly one cycle later (write latency 1).
REQ-020 Address counter SHALL increment by 1 per accepted byte.
REQ-021 Handshake with ld_last=1, or on address 2**ADDR_W-1, SHALL -> FLUSH; ld_ready SHALL be 0 from the next cycle; counter never wraps.
REQ-022 Both ld_last and final address on same handshake SHALL cause a single transition to FLUSH.
REQ-023 FLUSH: completes pending write (ram_we=1), then -> RELEASE.
REQ-024 RELEASE: cpu_rst=1 for exactly one cycle, cpu_hold=1, then -> RUN.
REQ-025 In all non-RUN states cpu_we SHALL be ignored; ram_we only from loader writes.
REQ-026 load_start outside RUN SHALL be ignored.
REQ-027 ld_valid while ld_ready=0 SHALL not write or advance counter.
REQ-028 Unloaded addresses SHALL retain prior RAM contents (no clearing).

Reset
REQ-029 rst SHALL asynchronously force state RUN, counter 0, ld_ready 0, cpu_hold 0, cpu_rst 0, load_busy 0, registered ram_we 0.
REQ-030 rst mid-LOAD SHALL abandon load; already-written bytes remain; no cpu_rst pulse.

Structure
REQ-031 Package cpu_pkg SHALL hold loader_state_t enum, DATA_W, ADDR_W defaults.
REQ-032 One sub-module load_addr_counter (clear, increment, terminal-count flag) SHALL be used.

Verification
REQ-033 load_start, fetch_boundary=1, stream 0x51,0x2E,0xE0,0xF0 with ld_last on 4th -> writes addr 0..3 with these values, one cpu_rst pulse, return RUN.
REQ-034 Stream 16 bytes 0x00..0x0F, no ld_last -> writes addr 0..15, ld_ready low after 16th, FLUSH then RELEASE.
REQ-035 load_start with fetch_boundary=0 for 5 cycles -> cpu_hold=1, ld_ready=0 until boundary, no RAM writes.
REQ-036 rst asserted after 2nd byte -> outputs reset immediately, addr 0/1 hold data, cpu_rst never pulses.
REQ-037 cpu_we=1, cpu_addr=0x7 during LOAD -> no CPU write reaches RAM; in RUN same stimulus -> ram_we=1, ram_addr=0x7.
REQ-038 ld_valid toggled with gaps; load_start repeated mid-load -> only handshaken bytes written, sequential addresses, no restart.
